// File: rtl/bp_lce_mem_arbiter_if.sv
// bp_lce_mem_arbiter_if: request/grant signals between the cache pipeline, the LCE and the shared mem port.
interface bp_lce_mem_arbiter_if;
  logic pipe_v_i;
  logic pipe_grant_o;
  logic pipe_busy_o;
  logic lce_v_i;
  logic lce_last_i;
  logic lce_yumi_o;
  logic mem_ready_i;
  logic mem_v_o;
  logic mem_sel_o;
  modport slave (
    input  pipe_v_i, lce_v_i, lce_last_i, mem_ready_i,
    output pipe_grant_o, pipe_busy_o, lce_yumi_o, mem_v_o, mem_sel_o
  );
  modport master (
    output pipe_v_i, lce_v_i, lce_last_i, mem_ready_i,
    input  pipe_grant_o, pipe_busy_o, lce_yumi_o, mem_v_o, mem_sel_o
  );
endinterface

// File: rtl/bp_lce_mem_arbiter.sv
// bp_lce_mem_arbiter: shares one tag/data/stat port between the cache pipeline and the LCE,
// with a stall timeout that forces LCE priority and a lock that keeps multi-beat LCE bursts intact.
module bp_lce_mem_arbiter #(
  parameter int timeout_max_limit_p = 4
) (
  input logic clk_i,
  input logic reset_i,
  bp_lce_mem_arbiter_if.slave bus
);
  localparam int cw = $clog2(timeout_max_limit_p + 1);
  localparam logic [cw-1:0] lim = cw'(timeout_max_limit_p);
  typedef enum logic [1:0] {e_pipe_pri, e_lce_pri, e_lce_lock} state_e;
  state_e state, state_n;
  logic [cw-1:0] cnt, cnt_n;
  logic rdy, pg, ly;
  always_comb begin
    rdy = bus.mem_ready_i & ~reset_i;
    pg = rdy & bus.pipe_v_i & ((state == e_pipe_pri) | ((state == e_lce_pri) & ~bus.lce_v_i));
    ly = rdy & bus.lce_v_i & ((state != e_pipe_pri) | ~bus.pipe_v_i);
    cnt_n = (bus.lce_v_i & ~ly) ? ((cnt == lim) ? cnt : cnt + 1'b1) : '0;
    // a consumed beat decides the next state before any timeout is considered
    state_n = ly ? (bus.lce_last_i ? e_pipe_pri : e_lce_lock)
            : ((state == e_pipe_pri) && (cnt_n == lim)) ? e_lce_pri : state;
  end
  assign bus.pipe_grant_o = pg;
  assign bus.lce_yumi_o   = ly;
  assign bus.mem_v_o      = pg | ly;
  assign bus.mem_sel_o    = ly;
  assign bus.pipe_busy_o  = reset_i | (state != e_pipe_pri) | (cnt == lim);
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= e_pipe_pri;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_bp_lce_mem_arbiter.sv
// tb_bp_lce_mem_arbiter: directed scenarios then random traffic, checked by a scoreboard against a behavioural model.
module tb_bp_lce_mem_arbiter;
  localparam int lim = 4;
  logic clk = 0;
  logic rst = 1;
  bp_lce_mem_arbiter_if bus();
  bp_lce_mem_arbiter #(.timeout_max_limit_p(lim)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {logic pg; logic ly; logic busy;} exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit m_locked = 0;
  bit m_favored = 0;
  int m_stall = 0;

  // one cycle of stimulus: drive inputs just after the edge and predict the response
  task automatic step(input bit pv, input bit lv, input bit last, input bit rdy, input bit r);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.pipe_v_i = pv;
    bus.lce_v_i = lv;
    bus.lce_last_i = last;
    bus.mem_ready_i = rdy;
    e.pg = 0;
    e.ly = 0;
    e.busy = 1;
    if (r) begin
      m_locked = 0;
      m_favored = 0;
      m_stall = 0;
    end else begin
      e.busy = m_locked || m_favored || m_stall == lim;
      if (rdy) begin
        if (m_locked) e.ly = lv;
        else if (m_favored) begin
          e.ly = lv;
          e.pg = pv && !lv;
        end else begin
          e.pg = pv;
          e.ly = lv && !pv;
        end
      end
      m_stall = (lv && !e.ly) ? ((m_stall + 1 > lim) ? lim : m_stall + 1) : 0;
      if (e.ly) begin
        m_locked = !last;
        m_favored = 0;
      end else if (!m_locked && !m_favored && m_stall == lim) m_favored = 1;
    end
    sb.push_back(e);
  endtask

  int wait_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (bus.pipe_grant_o !== e.pg || bus.lce_yumi_o !== e.ly || bus.pipe_busy_o !== e.busy ||
          bus.mem_v_o !== (e.pg | e.ly) || bus.mem_sel_o !== e.ly) begin
        fails++;
        $display("FAIL grants cycle %0d: got pg=%b ly=%b v=%b sel=%b busy=%b, want pg=%b ly=%b v=%b sel=%b busy=%b",
                 cyc, bus.pipe_grant_o, bus.lce_yumi_o, bus.mem_v_o, bus.mem_sel_o, bus.pipe_busy_o,
                 e.pg, e.ly, e.pg | e.ly, e.ly, e.busy);
      end
      if (!rst && bus.lce_v_i && !m_locked) begin
        if (bus.lce_yumi_o) begin
          tests++;
          if (wait_cnt > lim + 1) begin
            fails++;
            $display("FAIL lce_wait cycle %0d: waited %0d ready cycles, limit %0d", cyc, wait_cnt, lim + 1);
          end
          wait_cnt = 0;
        end else if (bus.mem_ready_i) wait_cnt++;
      end else if (!bus.lce_v_i || rst) wait_cnt = 0;
    end
    if (bus.pipe_grant_o && bus.lce_yumi_o) begin
      tests++;
      fails++;
      $display("FAIL exclusive cycle %0d: pg=%b ly=%b both set", cyc, bus.pipe_grant_o, bus.lce_yumi_o);
    end
  end

  initial begin
    bus.pipe_v_i = 0;
    bus.lce_v_i = 0;
    bus.lce_last_i = 0;
    bus.mem_ready_i = 0;
    step(1, 1, 0, 1, 1);
    step(1, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
    repeat (3) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
